// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared types and lane helpers for the sram_bw_pipe buffer SRAM.
// Revision : 1.0  initial release
// ============================================================================
package sram_pkg;

  // Upper bounds for the generic lane helpers; the top checks its
  // parameters against these at elaboration.
  localparam int MAX_DW    = 256;
  localparam int MAX_LANES = 32;
  localparam int DW_IW     = $clog2(MAX_DW);
  localparam int LANE_IW   = $clog2(MAX_LANES);

  typedef logic [MAX_DW-1:0]    max_word_t;
  typedef logic [MAX_LANES-1:0] max_be_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_e;

  function automatic int lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Lanes with be set take new_word, all other bits keep old_word.
  function automatic max_word_t byte_merge(input max_word_t old_word,
                                           input max_word_t new_word,
                                           input max_be_t   be,
                                           input int        byte_width);
    max_word_t res;
    int        lane;
    res = old_word;
    for (int b = 0; b < MAX_DW; b++) begin
      lane = b / byte_width;
      if (lane < MAX_LANES && be[LANE_IW'(lane)]) begin
        res[DW_IW'(b)] = new_word[DW_IW'(b)];
      end
    end
    return res;
  endfunction

  // Even parity per lane: bit l is the XOR of all bits in lane l.
  function automatic max_be_t lane_parity(input max_word_t data,
                                          input int        byte_width,
                                          input int        n_lanes);
    max_be_t par;
    int      lane;
    par = '0;
    for (int b = 0; b < MAX_DW; b++) begin
      lane = b / byte_width;
      if (lane < n_lanes && lane < MAX_LANES) begin
        par[LANE_IW'(lane)] = par[LANE_IW'(lane)] ^ data[DW_IW'(b)];
      end
    end
    return par;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sram_rd_pipe
// Purpose  : Read output pipeline (1 or 2 stages) carrying data, valid and,
//            with SRAM_PARITY_EN defined, the parity-error flag.
// Revision : 1.0  initial release
// ============================================================================
module sram_rd_pipe #(
  parameter int RD_LATENCY = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef SRAM_PARITY_EN
  input  logic                  in_perr,
  output logic                  out_perr,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  stg_valid;
  logic [DATA_WIDTH-1:0] stg_data;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef SRAM_PARITY_EN
  logic                  stg_perr;
  logic                  perr_q, perr_d;
`endif

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
`ifdef SRAM_PARITY_EN
    logic                  s1_perr_q, s1_perr_d;
`endif

    always_comb begin
      s1_valid_d = in_valid;
      s1_data_d  = in_data;
`ifdef SRAM_PARITY_EN
      s1_perr_d  = in_valid & in_perr;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
`ifdef SRAM_PARITY_EN
        s1_perr_q  <= 1'b0;
`endif
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
`ifdef SRAM_PARITY_EN
        s1_perr_q  <= s1_perr_d;
`endif
      end
    end

    assign stg_valid = s1_valid_q;
    assign stg_data  = s1_data_q;
`ifdef SRAM_PARITY_EN
    assign stg_perr  = s1_perr_q;
`endif
  end else begin : g_lat1
    assign stg_valid = in_valid;
    assign stg_data  = in_data;
`ifdef SRAM_PARITY_EN
    assign stg_perr  = in_perr;
`endif
  end

  // Output data only moves on a valid beat so dout holds between reads.
  always_comb begin
    valid_d = stg_valid;
    data_d  = stg_valid ? stg_data : data_q;
`ifdef SRAM_PARITY_EN
    perr_d  = stg_valid & stg_perr;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef SRAM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef SRAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
`ifdef SRAM_PARITY_EN
  assign out_perr  = perr_q;
`endif

endmodule
`default_nettype wire

// File: rtl/sram_bw_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sram_bw_pipe
// Purpose  : Simple dual-port buffer SRAM with byte-lane write enables,
//            1/2-cycle read latency, collision bypass and a post-reset clear
//            sweep. Define SRAM_PARITY_EN for per-lane parity and par_err.
// Revision : 1.0  initial release
// ============================================================================
module sram_bw_pipe
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 16384,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
`ifdef SRAM_PARITY_EN
  input  logic                             wr_par_flip,
  output logic                             par_err,
`endif
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             rd_valid,
  output logic                             init_done
);

  localparam int NL    = lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(DATA_DEPTH - 1);

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_chk_dw
    $error("sram_bw_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DATA_DEPTH > (2 ** ADDR_WIDTH)) begin : g_chk_depth
    $error("sram_bw_pipe: DATA_DEPTH exceeds the address range");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
    $error("sram_bw_pipe: RD_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH > MAX_DW || NL > MAX_LANES) begin : g_chk_max
    $error("sram_bw_pipe: word or lane count exceeds sram_pkg limits");
  end

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  logic                  run;
  logic                  wr_in_range, rd_in_range;
  logic                  wr_fire, rd_fire, collide;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [NL-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
      end
      default: state_d = ST_INIT;
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign run         = (state_q == ST_RUN);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_fire     = run && wr_en && wr_in_range;
  assign rd_fire     = run && rd_en;
  assign collide     = wr_fire && rd_fire && rd_in_range && (wr_addr == rd_addr);

`ifdef SRAM_PARITY_EN
  logic [NL-1:0] par_mem [DATA_DEPTH];
  logic [NL-1:0] wr_par, mem_wpar, rd_par_old, rd_par, rd_par_calc;
  logic          rd_perr;

  // wr_par_flip inverts stored parity to inject errors on enabled lanes.
  assign wr_par = NL'(lane_parity(max_word_t'(din), BYTE_WIDTH, NL)) ^ {NL{wr_par_flip}};
`endif

  // The sweep owns the write port until it finishes; user writes are ignored.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = init_cnt_q[IDX_W-1:0];
    mem_be    = '1;
    mem_wdata = '0;
`ifdef SRAM_PARITY_EN
    mem_wpar  = '0;
`endif
    if (!run) begin
      mem_we = 1'b1;
    end else if (wr_fire) begin
      mem_we    = 1'b1;
      mem_widx  = wr_idx;
      mem_be    = wr_be;
      mem_wdata = din;
`ifdef SRAM_PARITY_EN
      mem_wpar  = wr_par;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < NL; l++) begin
        if (mem_be[l]) begin
          mem[mem_widx][l*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

`ifdef SRAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < NL; l++) begin
        if (mem_be[l]) begin
          par_mem[mem_widx][l] <= mem_wpar[l];
        end
      end
    end
  end
`endif

  assign rd_old = mem[rd_idx];

  // Out-of-range reads still return a valid beat, with zero data.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = rd_old;
      if (collide && (BYPASS != 0)) begin
        rd_word = DATA_WIDTH'(byte_merge(max_word_t'(rd_old), max_word_t'(din),
                                         max_be_t'(wr_be), BYTE_WIDTH));
      end
    end
  end

`ifdef SRAM_PARITY_EN
  assign rd_par_old = par_mem[rd_idx];

  always_comb begin
    rd_par = rd_par_old;
    if (collide && (BYPASS != 0)) begin
      rd_par = NL'(byte_merge(max_word_t'(rd_par_old), max_word_t'(wr_par),
                              max_be_t'(wr_be), 1));
    end
  end

  assign rd_par_calc = NL'(lane_parity(max_word_t'(rd_word), BYTE_WIDTH, NL));
  assign rd_perr     = rd_in_range && (|(rd_par_calc ^ rd_par));
`endif

  sram_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
`ifdef SRAM_PARITY_EN
    .in_perr   (rd_perr),
    .out_perr  (par_err),
`endif
    .out_valid (rd_valid),
    .out_data  (dout)
  );

  assign init_done = init_done_q;

endmodule
`default_nettype wire
